fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch queue between the instruction fetch unit and decode. Each cycle it accepts one {PC, instruction} pair from fetch, buffers up to DEPTH pairs in program order, and presents the oldest to decode under a valid/ready handshake. When full it raises the fetch stall that holds the PC register. On a redirect (branch/jump resolved, exception) it drops every buffered pair.

## Interface
- DEPTH, 4, number of entries; power of two, ≥ 2
- CLK  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high; clears queue
- IF_PC  in  32  PC of instruction being fetched (fetch unit's current PC)
- IF_Instr  in  32  instruction word read at IF_PC
- IF_Valid  in  1  IF_PC/IF_Instr carry a real fetch this cycle
- Flush  in  1  redirect; discard all entries and this cycle's fetch
- IF_Stall  out  1  queue full; drives the fetch unit's npc_stall
- D_Valid  out  1  head entry present
- D_PC  out  32  PC of head entry
- D_Instr  out  32  instruction of head entry
- D_Ready  in  1  decode consumes head this cycle if D_Valid
- Q_Count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Storage: DEPTH entries of {PC[31:0], Instr[31:0]}; rd_ptr and wr_ptr, each $clog2(DEPTH) bits, wrap modulo DEPTH; count 0..DEPTH.
- push = IF_Valid & ~full & ~Flush; pop = D_Valid & D_Ready & ~Flush.
- full = (count == DEPTH); IF_Stall = full. Depends only on registered count; no combinational path from D_Ready or IF_Valid.
- Push writes entry[wr_ptr], wr_ptr+1. Pop advances rd_ptr+1. count += push − pop.
- Simultaneous push and pop with 0 < count < DEPTH: both happen, count unchanged.
- Empty queue with push and D_Ready: no bypass. The entry appears at D_Valid next cycle.
- Full queue with pop: pop happens. IF_Stall stays 1 this cycle. The fetch unit holds its PC, so the same pair is re-presented and accepted the next cycle.
- Flush: count, rd_ptr, wr_ptr go to 0. Same-cycle push and pop are suppressed. Flush overrides all other inputs except Reset.
- Reset: same as Flush. It also has priority over Flush. Storage contents are not cleared.
- D_Valid = (count != 0). When D_Valid = 0: D_PC = 32'h0000_0000, D_Instr = 32'h0000_0000 (nop). Otherwise D_PC and D_Instr come from entry[rd_ptr].
- D_Ready is ignored when D_Valid = 0.

## Timing
- After Reset cycle: D_Valid=0, D_PC=0, D_Instr=0, IF_Stall=0, Q_Count=0.
- Push-to-decode latency: 1 cycle (pair pushed at edge N is at D_* after edge N).
- Throughput: 1 push + 1 pop per cycle sustained when not full.
- Full → not full: IF_Stall deasserts the cycle after the first pop.
- Flush takes effect at the edge it is sampled. D_Valid=0 and IF_Stall=0 the following cycle.
- D_* outputs are combinational from registered state (head mux). No input-to-output combinational path.

## Structure
- Shared package holds:
  - NOP_INSTR = 32'h0000_0000
  - PC_RESET = 32'h0000_3000, so benches and the fetch unit share one constant
  - the {PC, Instr} entry typedef
- One sub-module is natural: fetch_queue_ram, a DEPTH×64 register array with one write port and one asynchronous read port. fetch_queue keeps the pointers, count and handshake logic.

## Test plan
- Reset, then IF_Valid=1 with PC 0x3000/0x3004/0x3008 on consecutive cycles, D_Ready=1 → D_Valid rises one cycle after the first push. D_PC reads 0x3000, 0x3004, 0x3008 in order. Q_Count ≤ 1.
- D_Ready=0, push 4 pairs (0x3000..0x300C) → Q_Count=4, IF_Stall=1. A 5th pair (0x3010) held for 2 cycles is not stored.
- Full, then one cycle with D_Ready=1 → pops 0x3000. IF_Stall=1 that cycle, 0 next. Held 0x3010 is then pushed, and order 0x3004..0x3010 is preserved.
- Wrap-around: 12 pushes interleaved with pops, keeping count between 1 and 3 → every PC emerges exactly once, in order, across pointer wrap.
- Queue holding 3 entries, Flush=1 with IF_Valid=1 and D_Ready=1 → next cycle Q_Count=0, D_Valid=0, D_Instr=0, IF_Stall=0. Nothing is pushed.
- Reset asserted mid-stream with Flush=0, Q_Count=2 → all outputs return to reset values the next cycle. The first post-reset push (PC 0x3000) is the next D_PC.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared constants and entry type for the instruction fetch queue and its users.
package fetch_queue_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_RESET  = 32'h0000_3000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  localparam int ENTRY_W = $bits(fq_entry_t);

endpackage

// File: rtl/fetch_queue_ram.sv
// DEPTH x {PC, Instr} register array: one synchronous write port, one asynchronous read port.
module fetch_queue_ram
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [ENTRY_W-1:0]       wr_data_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [ENTRY_W-1:0]       rd_data_o
);

  // Contents are deliberately never reset; occupancy lives in the pointers.
  fq_entry_t mem_q [DEPTH];

  always_ff @(posedge CLK) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= fq_entry_t'(wr_data_i);
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: buffers {PC, Instr} pairs from fetch in program order and
// presents the oldest to decode; stalls fetch when full and empties on a redirect.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic [31:0]                IF_PC,
  input  logic [31:0]                IF_Instr,
  input  logic                       IF_Valid,
  input  logic                       Flush,
  output logic                       IF_Stall,
  output logic                       D_Valid,
  output logic [31:0]                D_PC,
  output logic [31:0]                D_Instr,
  input  logic                       D_Ready,
  output logic [$clog2(DEPTH+1)-1:0] Q_Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // Handshakes: fetch side transfers when IF_Valid & ~IF_Stall, decode side when
  // D_Valid & D_Ready, both at the rising edge; Flush cancels both transfers that cycle.

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          full;
  logic          push;
  logic          pop;
  fq_entry_t     wr_entry;
  fq_entry_t     head_entry;
  logic [ENTRY_W-1:0] head_raw;

  assign full    = (count_q == CW'(DEPTH));
  assign D_Valid = (count_q != '0);
  assign push    = IF_Valid & ~full & ~Flush;
  assign pop     = D_Valid & D_Ready & ~Flush;

  assign wr_entry.pc    = IF_PC;
  assign wr_entry.instr = IF_Instr;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (Flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Power-of-two depth: pointer overflow is the wrap.
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  fetch_queue_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .CLK       (CLK),
    .wr_en_i   (push & ~Reset),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_entry),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (head_raw)
  );

  assign head_entry = fq_entry_t'(head_raw);

  // An empty queue shows a nop at address zero so decode never sees stale data.
  assign D_PC     = D_Valid ? head_entry.pc    : 32'h0000_0000;
  assign D_Instr  = D_Valid ? head_entry.instr : NOP_INSTR;
  assign IF_Stall = full;
  assign Q_Count  = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: cycle-by-cycle vector table plus a few hand sequences.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  // ---------------- clock / reset / DUT ----------------
  logic          CLK = 1'b0;
  logic          Reset;
  logic [31:0]   IF_PC;
  logic [31:0]   IF_Instr;
  logic          IF_Valid;
  logic          Flush;
  logic          IF_Stall;
  logic          D_Valid;
  logic [31:0]   D_PC;
  logic [31:0]   D_Instr;
  logic          D_Ready;
  logic [CW-1:0] Q_Count;

  always #5 CLK = ~CLK;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .IF_PC    (IF_PC),
    .IF_Instr (IF_Instr),
    .IF_Valid (IF_Valid),
    .Flush    (Flush),
    .IF_Stall (IF_Stall),
    .D_Valid  (D_Valid),
    .D_PC     (D_PC),
    .D_Instr  (D_Instr),
    .D_Ready  (D_Ready),
    .Q_Count  (Q_Count)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic          rst;
    logic          flush;
    logic          vld;
    logic [31:0]   pc;
    logic          rdy;
    logic          e_valid;
    logic [31:0]   e_pc;
    logic          e_stall;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  // Every fetched word is tagged from its PC so the instruction lane is checked too.
  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0000;
  endfunction

  function automatic void add(input logic rst, input logic flush, input logic vld,
                              input logic [31:0] pc, input logic rdy,
                              input logic e_valid, input logic [31:0] e_pc,
                              input logic e_stall, input int e_cnt);
    vec_t v;
    v.rst = rst; v.flush = flush; v.vld = vld; v.pc = pc; v.rdy = rdy;
    v.e_valid = e_valid; v.e_pc = e_pc; v.e_stall = e_stall; v.e_cnt = CW'(e_cnt);
    vecs.push_back(v);
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic drive(input logic rst, input logic flush, input logic vld,
                       input logic [31:0] pc, input logic rdy);
    Reset    = rst;
    Flush    = flush;
    IF_Valid = vld;
    IF_PC    = pc;
    IF_Instr = instr_of(pc);
    D_Ready  = rdy;
  endtask

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input int idx, input logic e_valid,
                               input logic [31:0] e_pc, input logic e_stall,
                               input logic [CW-1:0] e_cnt);
    logic [31:0] e_instr;
    e_instr = e_valid ? instr_of(e_pc) : NOP_INSTR;
    check({tag, ".D_Valid"},  idx, 32'(D_Valid),  32'(e_valid));
    check({tag, ".D_PC"},     idx, D_PC,          e_valid ? e_pc : 32'h0);
    check({tag, ".D_Instr"},  idx, D_Instr,       e_instr);
    check({tag, ".IF_Stall"}, idx, 32'(IF_Stall), 32'(e_stall));
    check({tag, ".Q_Count"},  idx, 32'(Q_Count),  32'(e_cnt));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    // rst flush vld pc rdy | valid pc stall cnt   (expected after the edge)
    add(1, 0, 0, 32'h0,    0,  0, 32'h0,    0, 0);  // reset state
    add(0, 0, 0, 32'h0,    1,  0, 32'h0,    0, 0);  // D_Ready on empty is ignored
    // streaming: push with decode always ready, no bypass
    add(0, 0, 1, PC_RESET,        1,  1, PC_RESET,        0, 1);
    add(0, 0, 1, PC_RESET + 4,    1,  1, PC_RESET + 4,    0, 1);
    add(0, 0, 1, PC_RESET + 8,    1,  1, PC_RESET + 8,    0, 1);
    add(0, 0, 0, 32'h0,           1,  0, 32'h0,           0, 0);
    // fill to full with decode stalled; held 5th pair is not stored
    add(0, 0, 1, 32'h3000, 0,  1, 32'h3000, 0, 1);
    add(0, 0, 1, 32'h3004, 0,  1, 32'h3000, 0, 2);
    add(0, 0, 1, 32'h3008, 0,  1, 32'h3000, 0, 3);
    add(0, 0, 1, 32'h300C, 0,  1, 32'h3000, 1, 4);
    add(0, 0, 1, 32'h3010, 0,  1, 32'h3000, 1, 4);
    add(0, 0, 1, 32'h3010, 0,  1, 32'h3000, 1, 4);
    // pop while full: push still blocked that edge, accepted on the next
    add(0, 0, 1, 32'h3010, 1,  1, 32'h3004, 0, 3);
    add(0, 0, 1, 32'h3010, 0,  1, 32'h3004, 1, 4);
    add(0, 0, 0, 32'h0,    1,  1, 32'h3008, 0, 3);
    add(0, 0, 0, 32'h0,    1,  1, 32'h300C, 0, 2);
    add(0, 0, 0, 32'h0,    1,  1, 32'h3010, 0, 1);
    add(0, 0, 0, 32'h0,    1,  0, 32'h0,    0, 0);
    // wrap-around: 12 pushes, count kept within 1..3
    add(0, 0, 1, 32'h4000, 0,  1, 32'h4000, 0, 1);
    add(0, 0, 1, 32'h4004, 0,  1, 32'h4000, 0, 2);
    add(0, 0, 1, 32'h4008, 1,  1, 32'h4004, 0, 2);
    add(0, 0, 1, 32'h400C, 1,  1, 32'h4008, 0, 2);
    add(0, 0, 1, 32'h4010, 0,  1, 32'h4008, 0, 3);
    add(0, 0, 1, 32'h4014, 1,  1, 32'h400C, 0, 3);
    add(0, 0, 1, 32'h4018, 1,  1, 32'h4010, 0, 3);
    add(0, 0, 1, 32'h401C, 1,  1, 32'h4014, 0, 3);
    add(0, 0, 1, 32'h4020, 1,  1, 32'h4018, 0, 3);
    add(0, 0, 1, 32'h4024, 1,  1, 32'h401C, 0, 3);
    add(0, 0, 1, 32'h4028, 1,  1, 32'h4020, 0, 3);
    add(0, 0, 1, 32'h402C, 1,  1, 32'h4024, 0, 3);
    add(0, 0, 0, 32'h0,    1,  1, 32'h4028, 0, 2);
    add(0, 0, 0, 32'h0,    1,  1, 32'h402C, 0, 1);
    add(0, 0, 0, 32'h0,    1,  0, 32'h0,    0, 0);
    // flush with 3 entries plus same-cycle push and pop
    add(0, 0, 1, 32'h5000, 0,  1, 32'h5000, 0, 1);
    add(0, 0, 1, 32'h5004, 0,  1, 32'h5000, 0, 2);
    add(0, 0, 1, 32'h5008, 0,  1, 32'h5000, 0, 3);
    add(0, 1, 1, 32'h500C, 1,  0, 32'h0,    0, 0);
    add(0, 0, 0, 32'h0,    0,  0, 32'h0,    0, 0);
    add(0, 0, 1, 32'h6000, 0,  1, 32'h6000, 0, 1);
    // flush while full clears the stall
    add(0, 0, 1, 32'h6004, 0,  1, 32'h6000, 0, 2);
    add(0, 0, 1, 32'h6008, 0,  1, 32'h6000, 0, 3);
    add(0, 0, 1, 32'h600C, 0,  1, 32'h6000, 1, 4);
    add(0, 1, 1, 32'h6010, 0,  0, 32'h0,    0, 0);
    // reset mid-stream with 2 entries
    add(0, 0, 1, 32'h8000, 0,  1, 32'h8000, 0, 1);
    add(0, 0, 1, 32'h8004, 0,  1, 32'h8000, 0, 2);
    add(1, 0, 1, 32'h8008, 1,  0, 32'h0,    0, 0);
    add(0, 0, 1, PC_RESET, 0,  1, PC_RESET, 0, 1);
    add(0, 0, 0, 32'h0,    1,  0, 32'h0,    0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].vld, vecs[i].pc, vecs[i].rdy);
      @(posedge CLK);
      #1;
      check_outputs("vec", i, vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_stall, vecs[i].e_cnt);
    end

    // Hand sequence: stall is registered, so raising D_Ready or IF_Valid mid-cycle
    // while full must not move IF_Stall before the edge.
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b0, 1'b0, 1'b1, 32'h9000 + 32'(k * 4), 1'b0);
      @(posedge CLK);
      #1;
    end
    check_outputs("full", 0, 1'b1, 32'h9000, 1'b1, CW'(DEPTH));
    drive(1'b0, 1'b0, 1'b1, 32'h9010, 1'b1);
    #2;
    check("comb.IF_Stall", 0, 32'(IF_Stall), 32'd1);
    check("comb.D_PC",     0, D_PC,          32'h9000);
    @(posedge CLK);
    #1;
    check_outputs("full_pop", 0, 1'b1, 32'h9004, 1'b0, CW'(DEPTH - 1));

    // Hand sequence: Reset beats a simultaneous Flush and a push.
    drive(1'b1, 1'b1, 1'b1, 32'h9014, 1'b1);
    @(posedge CLK);
    #1;
    check_outputs("rst_flush", 0, 1'b0, 32'h0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(posedge CLK);
    #1;
    check_outputs("idle", 0, 1'b0, 32'h0, 1'b0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
